// File: rtl/menu_pkg.sv
// Shared types and constants for the menu pushbutton front end.
package menu_pkg;

  typedef enum logic [2:0] {
    ST_ARM     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_HELD    = 3'd2,
    ST_REPEAT  = 3'd3,
    ST_RELEASE = 3'd4
  } btn_state_e;

  localparam int NUM_BTN     = 3;
  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_CONFIRM = 2;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;
  localparam int DEF_CNT_WIDTH       = 25;

  function automatic logic state_is_held(input btn_state_e st);
    logic v;
    case (st)
      ST_HELD, ST_REPEAT, ST_RELEASE: v = 1'b1;
      default:                        v = 1'b0;
    endcase
    return v;
  endfunction

  // Fixed priority up > down > confirm; losers are dropped.
  function automatic logic [NUM_BTN-1:0] arbitrate(input logic [NUM_BTN-1:0] req);
    logic [NUM_BTN-1:0] g;
    g[BTN_UP]      = req[BTN_UP];
    g[BTN_DOWN]    = req[BTN_DOWN] & ~req[BTN_UP];
    g[BTN_CONFIRM] = req[BTN_CONFIRM] & ~req[BTN_UP] & ~req[BTN_DOWN];
    return g;
  endfunction

endpackage

// File: rtl/btn_debounce_repeat.sv
// One pushbutton: 2-FF synchronizer, debounce FSM and optional auto-repeat.
// o_req is a combinational request; the top level registers and arbitrates it.
module btn_debounce_repeat
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_req,
  output logic o_held
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RD_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RP_LAST  = CNT_WIDTH'(REPEAT_PERIOD - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [1:0]           r_sync;
  btn_state_e           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_rcnt;
  logic                 r_was_repeat;
  logic                 r_held;

  logic                 w_s;
  btn_state_e           w_state_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_rcnt_nxt;
  logic                 w_was_repeat_nxt;
  logic                 w_req;

  assign w_s = r_sync[1];

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

  // State, counters and held level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_ARM;
      r_cnt        <= CNT_ZERO;
      r_rcnt       <= CNT_ZERO;
      r_was_repeat <= 1'b0;
      r_held       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rcnt       <= w_rcnt_nxt;
      r_was_repeat <= w_was_repeat_nxt;
      r_held       <= state_is_held(w_state_nxt);
    end
  end

  // Next state and counter updates.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_rcnt_nxt       = r_rcnt;
    w_was_repeat_nxt = r_was_repeat;
    case (r_state)
      ST_ARM: begin
        if (w_s) begin
          w_cnt_nxt = CNT_ZERO;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      ST_IDLE: begin
        if (!w_s) begin
          w_cnt_nxt = CNT_ZERO;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt      = ST_HELD;
          w_cnt_nxt        = CNT_ZERO;
          w_rcnt_nxt       = CNT_ZERO;
          w_was_repeat_nxt = 1'b0;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      ST_HELD: begin
        // The cycle that leaves HELD is the first of the release run.
        if (!w_s) begin
          w_state_nxt      = ST_RELEASE;
          w_cnt_nxt        = CNT_ONE;
          w_rcnt_nxt       = CNT_ZERO;
          w_was_repeat_nxt = 1'b0;
        end else if (REPEAT_EN && (r_rcnt == RD_LAST)) begin
          w_state_nxt = ST_REPEAT;
          w_rcnt_nxt  = CNT_ZERO;
        end else begin
          w_rcnt_nxt = sat_inc(r_rcnt);
        end
      end
      ST_REPEAT: begin
        if (!w_s) begin
          w_state_nxt      = ST_RELEASE;
          w_cnt_nxt        = CNT_ONE;
          w_rcnt_nxt       = CNT_ZERO;
          w_was_repeat_nxt = 1'b1;
        end else if (r_rcnt == RP_LAST) begin
          w_rcnt_nxt = CNT_ZERO;
        end else begin
          w_rcnt_nxt = sat_inc(r_rcnt);
        end
      end
      ST_RELEASE: begin
        if (w_s) begin
          w_state_nxt = r_was_repeat ? ST_REPEAT : ST_HELD;
          w_cnt_nxt   = CNT_ZERO;
          w_rcnt_nxt  = CNT_ZERO;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      default: begin
        w_state_nxt      = ST_ARM;
        w_cnt_nxt        = CNT_ZERO;
        w_rcnt_nxt       = CNT_ZERO;
        w_was_repeat_nxt = 1'b0;
      end
    endcase
  end

  // Press and repeat requests.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      ST_IDLE:   w_req = w_s && (r_cnt == DB_LAST);
      ST_HELD:   w_req = w_s && REPEAT_EN && (r_rcnt == RD_LAST);
      ST_REPEAT: w_req = w_s && (r_rcnt == RP_LAST);
      default:   w_req = 1'b0;
    endcase
  end

  assign o_req  = w_req;
  assign o_held = r_held;

endmodule

// File: rtl/menu_button_conditioner.sv
// Conditions the three menu pushbuttons into mutually exclusive one-cycle pulses.
module menu_button_conditioner
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up_raw,
  input  logic       down_raw,
  input  logic       confirm_raw,
  output logic       up_btn,
  output logic       down_btn,
  output logic       confirm_btn,
  output logic [2:0] held
);

  logic [NUM_BTN-1:0] w_req;
  logic [NUM_BTN-1:0] w_held;
  logic [NUM_BTN-1:0] w_grant;
  logic [NUM_BTN-1:0] r_pulse;

  btn_debounce_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_WIDTH(CNT_WIDTH), .REPEAT_EN(1'b1)
  ) u_up (
    .clk(clk), .reset(reset), .i_raw(up_raw),
    .o_req(w_req[BTN_UP]), .o_held(w_held[BTN_UP])
  );

  btn_debounce_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_WIDTH(CNT_WIDTH), .REPEAT_EN(1'b1)
  ) u_down (
    .clk(clk), .reset(reset), .i_raw(down_raw),
    .o_req(w_req[BTN_DOWN]), .o_held(w_held[BTN_DOWN])
  );

  btn_debounce_repeat #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_WIDTH(CNT_WIDTH), .REPEAT_EN(1'b0)
  ) u_confirm (
    .clk(clk), .reset(reset), .i_raw(confirm_raw),
    .o_req(w_req[BTN_CONFIRM]), .o_held(w_held[BTN_CONFIRM])
  );

  assign w_grant = arbitrate(w_req);

  // Registered pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pulse <= {NUM_BTN{1'b0}};
    end else begin
      r_pulse <= w_grant;
    end
  end

  assign up_btn      = r_pulse[BTN_UP];
  assign down_btn    = r_pulse[BTN_DOWN];
  assign confirm_btn = r_pulse[BTN_CONFIRM];
  assign held        = w_held;

endmodule

// File: tb/tb_menu_button_conditioner.sv
// Randomized and directed bench for menu_button_conditioner against a
// behavioural model built from run lengths and elapsed-time rules.
module tb_menu_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int SAT = 1000000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic up_raw = 1'b0, down_raw = 1'b0, confirm_raw = 1'b0;
  logic up_btn, down_btn, confirm_btn;
  logic [2:0] held;

  menu_button_conditioner #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_WIDTH(25)
  ) dut (
    .clk(clk), .reset(reset),
    .up_raw(up_raw), .down_raw(down_raw), .confirm_raw(confirm_raw),
    .up_btn(up_btn), .down_btn(down_btn), .confirm_btn(confirm_btn),
    .held(held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state: delayed pin copies, run lengths, debounced level, timers.
  int h1[3], h2[3], run0[3], run1[3], tmr[3];
  bit armed[3], dlev[3], rep[3];
  logic [2:0] exp_btn  = 3'b000;
  logic [2:0] exp_held = 3'b000;

  int pulse_cnt[3];
  int first_edge[3];
  int down_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      h1[b] = 0; h2[b] = 0; run0[b] = 0; run1[b] = 0; tmr[b] = 0;
      armed[b] = 1'b0; dlev[b] = 1'b0; rep[b] = 1'b0;
    end
    exp_btn  = 3'b000;
    exp_held = 3'b000;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    logic [2:0] req;
    int s;
    req = 3'b000;
    for (int b = 0; b < 3; b++) begin
      s = h2[b]; h2[b] = h1[b]; h1[b] = int'(raw[b]);
      if (s != 0) begin
        if (run1[b] < SAT) run1[b]++;
        run0[b] = 0;
      end else begin
        if (run0[b] < SAT) run0[b]++;
        run1[b] = 0;
      end
      if (!armed[b]) begin
        if (run0[b] == D) armed[b] = 1'b1;
      end else if (!dlev[b]) begin
        if (run1[b] == D) begin
          dlev[b] = 1'b1; req[b] = 1'b1; tmr[b] = 0; rep[b] = 1'b0;
        end
      end else if (s == 0) begin
        if (run0[b] == D) dlev[b] = 1'b0;
      end else if (run1[b] == 1) begin
        tmr[b] = 0;
      end else begin
        if (tmr[b] < SAT) tmr[b]++;
        if (b != 2 && !rep[b] && tmr[b] == RD) begin
          req[b] = 1'b1; rep[b] = 1'b1; tmr[b] = 0;
        end else if (rep[b] && tmr[b] == RP) begin
          req[b] = 1'b1; tmr[b] = 0;
        end
      end
      exp_held[b] = dlev[b];
    end
    exp_btn[0] = req[0];
    exp_btn[1] = req[1] & ~req[0];
    exp_btn[2] = req[2] & ~req[0] & ~req[1];
  endtask

  task automatic clear_log();
    for (int b = 0; b < 3; b++) begin
      pulse_cnt[b] = 0; first_edge[b] = -1;
    end
    down_q.delete();
  endtask

  task automatic step(input logic u, input logic d, input logic c);
    logic [2:0] got;
    up_raw = u; down_raw = d; confirm_raw = c;
    @(posedge clk);
    cyc++;
    if (reset) model_reset();
    else model_edge({c, d, u});
    @(negedge clk);
    check("up_btn", int'(up_btn), int'(exp_btn[0]));
    check("down_btn", int'(down_btn), int'(exp_btn[1]));
    check("confirm_btn", int'(confirm_btn), int'(exp_btn[2]));
    check("held", int'(held), int'(exp_held));
    got = {confirm_btn, down_btn, up_btn};
    for (int b = 0; b < 3; b++) begin
      if (got[b]) begin
        pulse_cnt[b]++;
        if (first_edge[b] < 0) first_edge[b] = cyc;
      end
    end
    if (down_btn) down_q.push_back(cyc);
  endtask

  task automatic do_reset(input int n, input logic u, input logic d, input logic c);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_pulses", int'({confirm_btn, down_btn, up_btn}), 0);
    check("rst_held", int'(held), 0);
    repeat (n) step(u, d, c);
    reset = 1'b0;
  endtask

  initial begin
    int t0, p;
    int lvl[3], rem[3];
    logic [2:0] rv;

    model_reset();
    clear_log();
    do_reset(3, 1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b0);

    // Clean up press: one pulse, 6 edges after the first edge seeing raw=1.
    clear_log();
    t0 = cyc;
    repeat (12) step(1'b1, 1'b0, 1'b0);
    check("up_latency", first_edge[0] - t0, 6);
    check("up_count", pulse_cnt[0], 1);
    check("up_held_lvl", int'(held), 1);
    repeat (10) step(1'b0, 1'b0, 1'b0);

    // Bounce every 2 cycles, then steady.
    clear_log();
    for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 0, 1'b0, 1'b0);
    check("bounce_count", pulse_cnt[0], 0);
    t0 = cyc;
    repeat (10) step(1'b1, 1'b0, 1'b0);
    check("steady_latency", first_edge[0] - t0, 6);
    check("steady_count", pulse_cnt[0], 1);
    repeat (10) step(1'b0, 1'b0, 1'b0);

    // Down held: repeats 20, 28, 36, 44, 52 after the press pulse.
    clear_log();
    t0 = cyc;
    for (int i = 0; i < 20 && down_q.size() == 0; i++) step(1'b0, 1'b1, 1'b0);
    p = (down_q.size() == 0) ? cyc : down_q[0];
    check("down_latency", p - t0, 6);
    while (cyc < p + 56) step(1'b0, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    check("down_count", down_q.size(), 6);
    for (int k = 1; k < 6; k++) begin
      if (k < down_q.size()) check("down_repeat_off", down_q[k] - p, 20 + 8 * (k - 1));
    end

    // Confirm never repeats.
    clear_log();
    repeat (60) step(1'b0, 1'b0, 1'b1);
    check("confirm_count", pulse_cnt[2], 1);
    repeat (10) step(1'b0, 1'b0, 1'b0);

    // Same-edge up and confirm: up wins, confirm dropped.
    clear_log();
    repeat (12) step(1'b1, 1'b0, 1'b1);
    check("tie_up_count", pulse_cnt[0], 1);
    check("tie_confirm_count", pulse_cnt[2], 0);
    repeat (10) step(1'b0, 1'b0, 1'b0);

    // Confirm held through reset is ignored until released.
    clear_log();
    do_reset(3, 1'b0, 1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b0, 1'b1);
    check("rst_held_confirm", pulse_cnt[2], 0);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b1);
    check("rearm_confirm", pulse_cnt[2], 1);
    repeat (10) step(1'b0, 1'b0, 1'b0);

    // Randomized bursts: short runs act as bounce, long runs press and repeat.
    for (int b = 0; b < 3; b++) begin
      lvl[b] = 0; rem[b] = 0;
    end
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = 1 - lvl[b];
          rem[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 70));
        end
        rem[b]--;
        rv[b] = (lvl[b] != 0);
      end
      if ($urandom_range(0, 999) == 0) do_reset(2, rv[0], rv[1], rv[2]);
      else step(rv[0], rv[1], rv[2]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
